i2c_reg_sequencer: RTL and testbench

//  Host-side sequencer placed directly upstream of the single-step I2C master (i2c_master_single).
//  - Converts one host request into the full START/TX/RX/STOP command chain for a byte-register access.

---
 rtl/i2c_pkg.sv | 85 ++++++++
 rtl/i2c_reg_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_i2c_reg_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// -----------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the I2C register sequencer and its single-step master.
//   - CMD_*     : master step command encoding (m_command)
//   - ST_*      : sequencer state encoding
//   - LAST_*    : terminal step index of the write / read command chains
//   - step_t    : one entry of the step table {cmd, data}
//   - step_cmd(): step table lookup for a byte-register access
// -----------------------------------------------------------------------------
package i2c_pkg;

    // Master step commands
    localparam logic [1:0] CMD_START = 2'd0;
    localparam logic [1:0] CMD_STOP  = 2'd1;
    localparam logic [1:0] CMD_TX    = 2'd2;
    localparam logic [1:0] CMD_RX    = 2'd3;

    // Sequencer states
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ISSUE   = 3'd1;
    localparam logic [2:0] ST_WAIT_HI = 3'd2;
    localparam logic [2:0] ST_WAIT_LO = 3'd3;
    localparam logic [2:0] ST_CHECK   = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    // Final (STOP) step index of each chain
    localparam logic [2:0] LAST_WR = 3'd4;
    localparam logic [2:0] LAST_RD = 3'd6;

    typedef struct packed {
        logic [1:0] cmd;
        logic [7:0] data;
    } step_t;

    // Write: START, TX {dev,0}, TX reg, TX wdata, STOP
    // Read : START, TX {dev,0}, TX reg, START, TX {dev,1}, RX, STOP
    function automatic step_t step_cmd(
        input logic       rw,
        input logic [2:0] step,
        input logic [6:0] dev,
        input logic [7:0] reg_a,
        input logic [7:0] wdata
    );
        step_t s;
        s.cmd  = CMD_START;
        s.data = 8'h00;
        case (step)
            3'd0: begin
                s.cmd = CMD_START;
            end
            3'd1: begin
                s.cmd  = CMD_TX;
                s.data = {dev, 1'b0};
            end
            3'd2: begin
                s.cmd  = CMD_TX;
                s.data = reg_a;
            end
            3'd3: begin
                if (rw) begin
                    s.cmd = CMD_START;          // repeated start
                end else begin
                    s.cmd  = CMD_TX;
                    s.data = wdata;
                end
            end
            3'd4: begin
                if (rw) begin
                    s.cmd  = CMD_TX;
                    s.data = {dev, 1'b1};
                end else begin
                    s.cmd = CMD_STOP;
                end
            end
            3'd5: begin
                s.cmd = CMD_RX;
            end
            default: begin
                s.cmd = CMD_STOP;
            end
        endcase
        return s;
    endfunction

endpackage

// File: rtl/i2c_reg_sequencer.sv
// -----------------------------------------------------------------------------
// i2c_reg_sequencer
// Turns one host register-access request into the START/TX/RX/STOP chain for
// a single-step I2C master, and reports read data, completion and errors.
//
// Ports
//   clk, reset_n            : system clock, async active-low reset
//   start, rw               : host request strobe (IDLE only), 0 write / 1 read
//   dev_addr, reg_addr,
//   wdata                   : access target and write byte
//   busy, done              : sequencer-or-master busy, 1-cycle completion pulse
//   nack_err, tout_err      : held from done until the next accepted start
//   rdata                   : last successfully read byte
//   m_command, m_start,
//   m_data_w, m_r_ack       : step request to the master
//   m_busy, m_w_ack,
//   m_data_r                : step status from the master
//
// State table
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   IDLE     | waiting for start with the master idle
//   ISSUE    | present current step to master, m_start high for this cycle
//   WAIT_HI  | wait for master to report busy (watchdog running)
//   WAIT_LO  | wait for master to finish the step (watchdog running)
//   CHECK    | evaluate ACK / capture RX data / advance or finish
//   DONE     | done pulse, then back to IDLE
// -----------------------------------------------------------------------------
module i2c_reg_sequencer
    import i2c_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] dev_addr,
    input  logic [7:0] reg_addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic       nack_err,
    output logic       tout_err,
    output logic [7:0] rdata,
    output logic [1:0] m_command,
    output logic       m_start,
    output logic [7:0] m_data_w,
    output logic       m_r_ack,
    input  logic       m_busy,
    input  logic       m_w_ack,
    input  logic [7:0] m_data_r
);

    localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WD_W-1:0] WD_LOAD =
        WD_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 32'd0);
    localparam bit WD_EN = (TIMEOUT_CYCLES != 0);

    logic [2:0]      state_q, state_d;
    logic [2:0]      step_q,  step_d;
    logic            rw_q,    rw_d;
    logic [6:0]      dev_q,   dev_d;
    logic [7:0]      reg_q,   reg_d;
    logic [7:0]      wdat_q,  wdat_d;
    logic            nack_q,  nack_d;
    logic            tout_q,  tout_d;
    logic [7:0]      rdata_q, rdata_d;
    logic [1:0]      cmd_q,   cmd_d;
    logic [7:0]      data_q,  data_d;
    logic [WD_W-1:0] wd_q,    wd_d;

    step_t      cur;
    logic [2:0] last_step;
    logic       wd_expired;

    assign cur        = step_cmd(rw_q, step_q, dev_q, reg_q, wdat_q);
    assign last_step  = rw_q ? LAST_RD : LAST_WR;
    assign wd_expired = WD_EN && (wd_q == '0);

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        rw_d    = rw_q;
        dev_d   = dev_q;
        reg_d   = reg_q;
        wdat_d  = wdat_q;
        nack_d  = nack_q;
        tout_d  = tout_q;
        rdata_d = rdata_q;
        cmd_d   = cmd_q;
        data_d  = data_q;
        wd_d    = wd_q;

        case (state_q)
            ST_IDLE: begin
                if (start && !m_busy) begin
                    rw_d    = rw;
                    dev_d   = dev_addr;
                    reg_d   = reg_addr;
                    wdat_d  = wdata;
                    nack_d  = 1'b0;
                    tout_d  = 1'b0;
                    step_d  = 3'd0;
                    state_d = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                // Hold the command after the strobe so the master sees stable data.
                cmd_d   = cur.cmd;
                data_d  = cur.data;
                wd_d    = WD_LOAD;
                state_d = ST_WAIT_HI;
            end

            ST_WAIT_HI, ST_WAIT_LO: begin
                if (wd_q != '0) begin
                    wd_d = wd_q - WD_W'(1);
                end
                // Normal progress wins over an expiry in the same cycle.
                if ((state_q == ST_WAIT_HI) && m_busy) begin
                    state_d = ST_WAIT_LO;
                end else if ((state_q == ST_WAIT_LO) && !m_busy) begin
                    state_d = ST_CHECK;
                end else if (wd_expired) begin
                    // Bus state is unknown after a hung step: no STOP attempt.
                    tout_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end

            ST_CHECK: begin
                if ((cmd_q == CMD_TX) && m_w_ack) begin
                    nack_d  = 1'b1;
                    step_d  = last_step;
                    state_d = ST_ISSUE;
                end else begin
                    if (cmd_q == CMD_RX) begin
                        rdata_d = m_data_r;
                    end
                    // STOP has no ACK, so the abort STOP also terminates here.
                    if (step_q == last_step) begin
                        state_d = ST_DONE;
                    end else begin
                        step_d  = step_q + 3'd1;
                        state_d = ST_ISSUE;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            step_q  <= 3'd0;
            rw_q    <= 1'b0;
            dev_q   <= 7'h00;
            reg_q   <= 8'h00;
            wdat_q  <= 8'h00;
            nack_q  <= 1'b0;
            tout_q  <= 1'b0;
            rdata_q <= 8'h00;
            cmd_q   <= CMD_START;
            data_q  <= 8'h00;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            rw_q    <= rw_d;
            dev_q   <= dev_d;
            reg_q   <= reg_d;
            wdat_q  <= wdat_d;
            nack_q  <= nack_d;
            tout_q  <= tout_d;
            rdata_q <= rdata_d;
            cmd_q   <= cmd_d;
            data_q  <= data_d;
            wd_q    <= wd_d;
        end
    end

    // In ISSUE the table entry goes out directly so m_start and the command
    // arrive at the master in the same cycle.
    assign m_start   = (state_q == ST_ISSUE);
    assign m_command = m_start ? cur.cmd  : cmd_q;
    assign m_data_w  = m_start ? cur.data : data_q;
    assign m_r_ack   = 1'b1;

    assign busy     = (state_q != ST_IDLE) || m_busy;
    assign done     = (state_q == ST_DONE);
    assign nack_err = nack_q;
    assign tout_err = tout_q;
    assign rdata    = rdata_q;

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
`timescale 1ns/1ps
module tb_i2c_reg_sequencer;
    import i2c_pkg::*;

    localparam int TOUT = 50;
    localparam logic [6:0] SLAVE = 7'h50;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       rw = 1'b0;
    logic [6:0] dev_addr = 7'h00;
    logic [7:0] reg_addr = 8'h00;
    logic [7:0] wdata = 8'h00;
    logic       busy, done, nack_err, tout_err;
    logic [7:0] rdata;
    logic [1:0] m_command;
    logic       m_start;
    logic [7:0] m_data_w;
    logic       m_r_ack;
    logic       m_busy, m_w_ack;
    logic [7:0] m_data_r;

    always #5 clk = ~clk;

    i2c_reg_sequencer #(.TIMEOUT_CYCLES(TOUT)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .rw(rw),
        .dev_addr(dev_addr), .reg_addr(reg_addr), .wdata(wdata),
        .busy(busy), .done(done), .nack_err(nack_err), .tout_err(tout_err),
        .rdata(rdata), .m_command(m_command), .m_start(m_start),
        .m_data_w(m_data_w), .m_r_ack(m_r_ack), .m_busy(m_busy),
        .m_w_ack(m_w_ack), .m_data_r(m_data_r)
    );

    int checks = 0;
    int failures = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endfunction

    // ---------------- scoreboard of expected bus steps ----------------
    logic [9:0] exp_q[$];

    function automatic void push_tok(logic [1:0] c, logic [7:0] d);
        exp_q.push_back({c, (c == CMD_TX) ? d : 8'h00});
    endfunction

    // ---------------- behavioural master + bus slave ----------------
    logic       mdl_rst_n = 1'b0;
    int         nack_idx = -1;
    logic [7:0] slave_rd = 8'h00;
    int         busy_len = 3;
    logic       hang = 1'b0;
    int         bcnt;
    int         data_idx;
    logic       addr_phase;
    int         tok_cnt;
    logic [9:0] obs_tok;
    logic [9:0] exp_tok;
    int         cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge mdl_rst_n) begin
        if (!mdl_rst_n) begin
            m_busy     <= 1'b0;
            m_w_ack    <= 1'b0;
            m_data_r   <= 8'h00;
            bcnt       <= 0;
            data_idx   <= 0;
            addr_phase <= 1'b0;
            tok_cnt    <= 0;
        end else if (m_start && !m_busy) begin
            obs_tok = (m_command == CMD_TX) ? {m_command, m_data_w} : {m_command, 8'h00};
            tok_cnt <= tok_cnt + 1;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL bus_extra_step actual=0x%0h required=none", obs_tok);
            end else begin
                exp_tok = exp_q.pop_front();
                check("bus_step", {22'd0, obs_tok}, {22'd0, exp_tok});
            end
            m_busy <= 1'b1;
            bcnt   <= busy_len;
            case (m_command)
                CMD_START: begin
                    addr_phase <= 1'b1;
                    data_idx   <= 0;
                    m_w_ack    <= 1'b0;
                end
                CMD_TX: begin
                    if (addr_phase) begin
                        addr_phase <= 1'b0;
                        m_w_ack    <= (m_data_w[7:1] != SLAVE);
                    end else begin
                        m_w_ack  <= (data_idx == nack_idx);
                        data_idx <= data_idx + 1;
                    end
                end
                CMD_RX: begin
                    m_data_r <= slave_rd;
                    m_w_ack  <= 1'b1;
                end
                default: m_w_ack <= 1'b0;
            endcase
        end else if (m_busy && !hang) begin
            if (bcnt <= 1) m_busy <= 1'b0;
            else bcnt <= bcnt - 1;
        end
    end

    // ---------------- transaction vectors ----------------
    typedef struct {
        logic       rw;
        logic [6:0] dev;
        logic [7:0] rg;
        logic [7:0] wd;
        logic [7:0] srd;
        int         nidx;
        logic       exp_nack;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t vecs[8];

    // Expected bus sequence derived from the access rules and slave behaviour.
    function automatic void push_expected(vec_t v);
        push_tok(CMD_START, 8'h00);
        push_tok(CMD_TX, {v.dev, 1'b0});
        if (v.dev != SLAVE) begin
            push_tok(CMD_STOP, 8'h00);
            return;
        end
        push_tok(CMD_TX, v.rg);
        if (v.nidx == 0) begin
            push_tok(CMD_STOP, 8'h00);
            return;
        end
        if (!v.rw) begin
            push_tok(CMD_TX, v.wd);
            push_tok(CMD_STOP, 8'h00);
            return;
        end
        push_tok(CMD_START, 8'h00);
        push_tok(CMD_TX, {v.dev, 1'b1});
        push_tok(CMD_RX, 8'h00);
        push_tok(CMD_STOP, 8'h00);
    endfunction

    task automatic pulse_start(logic r, logic [6:0] d, logic [7:0] ra, logic [7:0] w);
        @(negedge clk);
        start = 1'b1; rw = r; dev_addr = d; reg_addr = ra; wdata = w;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_txn(vec_t v, string tag);
        int c;
        int dp;
        nack_idx = v.nidx;
        slave_rd = v.srd;
        push_expected(v);
        pulse_start(v.rw, v.dev, v.rg, v.wd);
        c = 0;
        dp = 0;
        while (c < 400 && dp == 0) begin
            @(negedge clk);
            c++;
            if (done) dp++;
        end
        check({tag, "_done_seen"}, dp, 1);
        repeat (4) begin
            @(negedge clk);
            if (done) dp++;
        end
        check({tag, "_done_pulses"}, dp, 1);
        check({tag, "_nack_err"}, nack_err, v.exp_nack);
        check({tag, "_tout_err"}, tout_err, 1'b0);
        check({tag, "_rdata"}, rdata, v.exp_rdata);
        check({tag, "_busy_after"}, busy, 1'b0);
        check({tag, "_steps_left"}, exp_q.size(), 0);
    endtask

    initial begin
        int c;
        int t_start;
        int t_done;
        int tok_snap;
        vec_t v;

        //          rw    dev    reg    wd     srd    nidx exp_nack rdata
        vecs[0] = '{1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, -1, 1'b0, 8'h00};
        vecs[1] = '{1'b1, 7'h50, 8'h22, 8'h00, 8'h3C, -1, 1'b0, 8'h3C};
        vecs[2] = '{1'b0, 7'h51, 8'h33, 8'h77, 8'h00, -1, 1'b1, 8'h3C};
        vecs[3] = '{1'b0, 7'h50, 8'h11, 8'h5A, 8'h00,  1, 1'b1, 8'h3C};
        vecs[4] = '{1'b1, 7'h50, 8'h05, 8'h00, 8'h96, -1, 1'b0, 8'h96};
        vecs[5] = '{1'b1, 7'h51, 8'h05, 8'h00, 8'h11, -1, 1'b1, 8'h96};
        vecs[6] = '{1'b0, 7'h50, 8'h44, 8'hC3, 8'h00,  0, 1'b1, 8'h96};
        vecs[7] = '{1'b1, 7'h50, 8'h07, 8'h00, 8'hE1,  0, 1'b1, 8'h96};

        repeat (2) @(negedge clk);
        mdl_rst_n = 1'b1;
        reset_n = 1'b1;
        @(negedge clk);

        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_nack", nack_err, 1'b0);
        check("rst_tout", tout_err, 1'b0);
        check("rst_rdata", rdata, 8'h00);
        check("rst_m_start", m_start, 1'b0);
        check("rst_m_cmd", m_command, 2'd0);
        check("rst_m_data", m_data_w, 8'h00);
        check("rst_m_r_ack", m_r_ack, 1'b1);

        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i], $sformatf("vec%0d", i));
        end

        // ---- extra start mid-transaction, then reset during the reg byte ----
        busy_len = 20;
        push_tok(CMD_START, 8'h00);
        push_tok(CMD_TX, 8'hA0);
        push_tok(CMD_TX, 8'h10);
        nack_idx = -1;
        tok_snap = tok_cnt;
        pulse_start(1'b0, 7'h50, 8'h10, 8'h99);
        c = 0;
        while (c < 200 && tok_cnt < tok_snap + 1) begin @(negedge clk); c++; end
        pulse_start(1'b1, 7'h50, 8'h66, 8'h00);
        c = 0;
        while (c < 400 && tok_cnt < tok_snap + 3) begin @(negedge clk); c++; end
        check("rst_mid_reached_step2", tok_cnt - tok_snap, 3);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_done", done, 1'b0);
        check("rst_mid_nack", nack_err, 1'b0);
        check("rst_mid_tout", tout_err, 1'b0);
        check("rst_mid_rdata", rdata, 8'h00);
        check("rst_mid_m_start", m_start, 1'b0);
        check("rst_mid_m_cmd", m_command, 2'd0);
        check("rst_mid_m_data", m_data_w, 8'h00);
        check("rst_mid_m_r_ack", m_r_ack, 1'b1);
        check("rst_mid_busy_follows", busy, 1'b1);
        check("rst_mid_steps_left", exp_q.size(), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        check("post_rst_busy_master", busy, m_busy);
        tok_snap = tok_cnt;
        pulse_start(1'b0, 7'h50, 8'h77, 8'h12);
        c = 0;
        while (c < 200 && m_busy) begin @(negedge clk); c++; end
        repeat (3) @(negedge clk);
        check("post_rst_start_ignored", tok_cnt - tok_snap, 0);
        check("post_rst_busy_low", busy, 1'b0);
        busy_len = 3;
        v = '{1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, -1, 1'b0, 8'h00};
        run_txn(v, "post_rst");

        // ---- watchdog: master hangs on the first step ----
        hang = 1'b1;
        push_tok(CMD_START, 8'h00);
        tok_snap = tok_cnt;
        t_start = -1;
        t_done = -1;
        @(negedge clk);
        start = 1'b1; rw = 1'b0; dev_addr = 7'h50; reg_addr = 8'h01; wdata = 8'h02;
        c = 0;
        while (c < 300 && t_done < 0) begin
            @(negedge clk);
            start = 1'b0;
            c++;
            if (m_start && t_start < 0) t_start = cyc;
            if (done && t_done < 0) t_done = cyc;
        end
        check("tout_done_seen", (t_done >= 0 && t_start >= 0), 1'b1);
        check("tout_latency_ok", ((t_done - t_start) >= TOUT - 2) && ((t_done - t_start) <= TOUT + 2), 1'b1);
        check("tout_err", tout_err, 1'b1);
        check("tout_nack", nack_err, 1'b0);
        repeat (5) @(negedge clk);
        check("tout_no_stop", tok_cnt - tok_snap, 1);
        check("tout_busy_master", busy, 1'b1);
        check("tout_steps_left", exp_q.size(), 0);
        hang = 1'b0;
        c = 0;
        while (c < 100 && m_busy) begin @(negedge clk); c++; end
        run_txn(vecs[4], "after_tout");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
